// File: rtl/pipe_pkg.sv
// Shared encodings and defaults for the D-stage pipeline sequencing controller.
// Optional HI/LO occupancy tracking is enabled by defining PIPE_HAZARD_MD_EN.
package pipe_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TUSE_W = 2;
    localparam int unsigned TNEW_W = 2;
    localparam int unsigned CNT_W  = 4;

    // Tuse: cycles until the D-stage operand is consumed
    localparam logic [TUSE_W-1:0] TUSE_0    = 2'd0;
    localparam logic [TUSE_W-1:0] TUSE_1    = 2'd1;
    localparam logic [TUSE_W-1:0] TUSE_2    = 2'd2;
    localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

    // Tnew: cycles until a producer's result can be forwarded
    localparam logic [TNEW_W-1:0] TNEW_0 = 2'd0;
    localparam logic [TNEW_W-1:0] TNEW_1 = 2'd1;
    localparam logic [TNEW_W-1:0] TNEW_2 = 2'd2;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

    // True when a D-stage source must wait for an in-flight producer
    function automatic logic src_hazard(
        input logic [REG_W-1:0]  src,
        input logic [TUSE_W-1:0] tuse,
        input logic [REG_W-1:0]  e_wa,
        input logic [TNEW_W-1:0] e_tnew,
        input logic [REG_W-1:0]  m_wa,
        input logic [TNEW_W-1:0] m_tnew
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src == e_wa) && (e_tnew > tuse);
        hit_m = (src == m_wa) && (m_tnew > tuse);
        return (src != '0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// HI/LO unit occupancy tracker: idle/mult/div FSM with a down-counter.
// Only instantiated when PIPE_HAZARD_MD_EN is defined.
module md_busy_ctr
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic kill,
    output logic busy
);

    md_state_t              state_q;
    md_state_t              state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    // State and counter registers; reset drops occupancy immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a start younger than a taken exception is discarded
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start && !kill) begin
                    if (is_div) begin
                        state_d = MD_DIV;
                        cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    end else begin
                        state_d = MD_MULT;
                        cnt_d   = CNT_W'(MULT_CYCLES - 1);
                    end
                end
            end
            MD_MULT, MD_DIV: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Occupancy is a pure decode of the current state
    always_comb begin
        busy = 1'b0;
        if (state_q != MD_IDLE) begin
            busy = 1'b1;
        end
    end

    // D-stage stalling on busy makes a start during an operation unreachable
    start_while_busy : assert property (
        @(posedge clk) disable iff (reset) !(start && (state_q != MD_IDLE))
    );

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// D-stage sequencing controller: drives PC, IF/ID and ID/EX enables from
// register dependencies, HI/LO occupancy, eret/EPC ordering and exception entry.
// Define PIPE_HAZARD_MD_EN to include HI/LO occupancy tracking.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  d_rs,
    input  logic [REG_W-1:0]  d_rt,
    input  logic [TUSE_W-1:0] d_rs_tuse,
    input  logic [TUSE_W-1:0] d_rt_tuse,
    input  logic              d_md,
    input  logic              d_eret,
    input  logic [REG_W-1:0]  e_wa,
    input  logic [REG_W-1:0]  m_wa,
    input  logic [TNEW_W-1:0] e_tnew,
    input  logic [TNEW_W-1:0] m_tnew,
    input  logic              e_md_start,
    input  logic              e_md_div,
    input  logic              e_mtc0_epc,
    input  logic              m_mtc0_epc,
    input  logic              req,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_flush,
    output logic              md_busy,
    output logic              stall
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall_eret;
    logic stall_any;

    assign stall_rs = src_hazard(d_rs, d_rs_tuse, e_wa, e_tnew, m_wa, m_tnew);
    assign stall_rt = src_hazard(d_rt, d_rt_tuse, e_wa, e_tnew, m_wa, m_tnew);

    // eret must wait until any in-flight EPC write has retired
    assign stall_eret = d_eret && (e_mtc0_epc || m_mtc0_epc);

`ifdef PIPE_HAZARD_MD_EN
    md_busy_ctr #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_ctr (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_start),
        .is_div (e_md_div),
        .kill   (req),
        .busy   (md_busy)
    );

    // HI/LO users wait while the unit is busy or about to start
    assign stall_md = d_md && (md_busy || e_md_start);
`else
    logic unused_md;

    // No HI/LO unit: occupancy inputs, clocking and cycle counts are don't-care
    assign unused_md = ^{clk, reset, e_md_start, e_md_div, d_md,
                         CNT_W'(MULT_CYCLES), CNT_W'(DIV_CYCLES)};
    assign md_busy   = 1'b0;
    assign stall_md  = 1'b0;
`endif

    // Exception entry overrides any stall so the handler fetch proceeds
    assign stall_any = stall_rs | stall_rt | stall_md | stall_eret;
    assign stall     = stall_any & ~req;

    // Enable decode: exception entry, then stall, then normal flow
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_flush = 1'b0;
        if (req) begin
            id_ex_flush = 1'b1;
        end else if (stall_any) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. Generates the IF/ID hold, PC hold and ID/EX bubble controls from register-dependency (Tuse/Tnew) checks, tracks multiply/divide occupancy with a cycle counter, and resolves interaction with exception entry (`req`) and `eret`. Sits beside the D stage and drives the enables of the PC register, the IF/ID register and the ID/EX register.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy cycles after `mult`/`multu` start
- `DIV_CYCLES`, 10, busy cycles after `div`/`divu` start

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `d_rs`, `d_rt`  in  5  D-stage source registers
- `d_rs_tuse`, `d_rt_tuse`  in  2  cycles until operand needed (0..2; 3 = unused)
- `d_md`  in  1  D instruction uses the HI/LO unit (mult/div/mf/mt)
- `d_eret`  in  1  D instruction is `eret`
- `e_wa`, `m_wa`  in  5  E/M destination register (0 = none)
- `e_tnew`, `m_tnew`  in  2  cycles until E/M result is forwardable
- `e_md_start`  in  1  E instruction is mult/div (start request)
- `e_md_div`  in  1  qualifies `e_md_start`: 1 = divide
- `e_mtc0_epc`, `m_mtc0_epc`  in  1  `mtc0` to EPC in E/M
- `req`  in  1  exception/interrupt taken at M this cycle
- `pc_en`  out  1  PC register enable
- `if_id_en`  out  1  IF/ID register enable
- `id_ex_flush`  out  1  load bubble into ID/EX
- `md_busy`  out  1  HI/LO unit occupied
- `stall`  out  1  D-stage stall indicator

## Operation
- Data hazard: `stall_rs = (d_rs!=0) && ((d_rs==e_wa && e_tnew>d_rs_tuse) || (d_rs==m_wa && m_tnew>d_rs_tuse))`; likewise `stall_rt`. `tuse==3` never stalls.
- MD hazard: `stall_md = d_md && (md_busy || e_md_start)`.
- ERET hazard: `stall_eret = d_eret && (e_mtc0_epc || m_mtc0_epc)`.
- `stall = (stall_rs | stall_rt | stall_md | stall_eret) & ~req`.
- Outputs, priority order:
  - `req`: `pc_en=1`, `if_id_en=1`, `id_ex_flush=1`. IF/ID itself loads the handler PC.
  - `stall`: `pc_en=0`, `if_id_en=0`, `id_ex_flush=1`.
  - otherwise: `pc_en=1`, `if_id_en=1`, `id_ex_flush=0`.
- MD FSM states: IDLE, MULT, DIV; 4-bit down-counter `cnt`.
  - IDLE: `e_md_start & ~req` loads `cnt=MULT_CYCLES-1` (MULT) or `DIV_CYCLES-1` (DIV).
  - MULT/DIV: decrement each cycle; at `cnt==0` return to IDLE.
- `e_md_start` while not IDLE: ignored; D-stage stalling makes it unreachable, and it is an assertion target.
- `req` with `e_md_start`: start suppressed because the E instruction is younger than the faulting one. `req` while MULT/DIV: the operation completes.
- `md_busy = (state != IDLE)`.
- All hazard outputs are combinational. Only the MD FSM and counter are registered.

## Timing
- Reset values: state IDLE, `cnt=0`, `md_busy=0`. With inputs idle: `pc_en=1`, `if_id_en=1`, `id_ex_flush=0`, `stall=0`.
- Start accepted at edge T sets `md_busy=1` from T+1 through T+N (N = MULT_CYCLES or DIV_CYCLES). A D-stage `mfhi` may issue in the cycle after `md_busy` falls.
- A start accepted on the same edge that `cnt` reaches 0 cannot occur.
- Reset mid-operation returns to IDLE immediately; `md_busy` deasserts asynchronously.
- Zero-cycle latency from hazard inputs to enables.

## Configuration
- `PIPE_HAZARD_MD_EN` defined: MD FSM, counter and `stall_md` are present.
- Macro absent: `md_busy` is tied to 0, `stall_md` is 0, and `e_md_start`/`e_md_div` are unused. This build targets cores without the HI/LO unit.

## Structure
- Shared package `pipe_pkg`:
  - Tuse/Tnew encodings, including `TUSE_NONE=2'd3`
  - MD state enum
  - default MULT/DIV cycle constants
- Sub-module `md_busy_ctr`: MD FSM plus counter, with ports `clk`, `reset`, `start`, `is_div`, `kill`, `busy`. Omitted when the macro is absent.

## Test plan
- Load-use: `e_wa=8`, `e_tnew=2`, `d_rs=8`, `d_rs_tuse=1` -> `stall=1`, `pc_en=0`, `if_id_en=0`, `id_ex_flush=1`. With `e_tnew=1`, no stall.
- $0 and unused operand: `d_rs=0` or `d_rs_tuse=3` against a matching `e_wa` -> `stall=0`.
- Mult: `e_md_start=1`, `e_md_div=0` at edge T -> `md_busy` high for exactly 5 cycles. D-stage `d_md=1` stalls until `md_busy` falls. Div variant gives 10 cycles.
- Req kills start: `e_md_start=1` with `req=1` -> `md_busy` stays 0, `id_ex_flush=1`, `pc_en=1`.
- ERET: `d_eret=1`, `m_mtc0_epc=1` -> `stall=1`. The next cycle with `mtc0` retired -> `stall=0`.
- Reset mid-divide at cycle 4 -> `md_busy=0` immediately. The FSM is IDLE after release.
